// File: rtl/bcd_to_bin_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_if
// Purpose  : Request/result bundle between the control logic (master) and the
//            BCD-to-binary converter (slave): start/busy/done handshake, the
//            packed BCD operand and the binary result with its error flag.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_to_bin_if #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    // Control side: issues requests, consumes results.
    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    // Converter side.
    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Sequential BCD-to-binary converter using reverse double dabble
//            (shift right one bit per cycle, subtract 3 from every BCD digit
//            that ends up >= 8). Inputs with any digit > 9 are rejected with
//            err=1 and a zero result.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  wire logic     sys_clk,
    input  wire logic     sys_rst_n,
    bcd_to_bin_if.slave   bus
);

    localparam int c_BCD_W  = 4 * DIGITS;
    localparam int c_WORK_W = c_BCD_W + BIN_W;
    localparam int c_CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_WORK_W-1:0]   r_work;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_invalid;
    logic                  r_busy;
    logic                  r_done;
    logic [BIN_W-1:0]      r_bin;
    logic                  r_err;

    logic [c_WORK_W-1:0]   w_shift;
    logic [c_WORK_W-1:0]   w_next;
    logic [DIGITS-1:0]     w_nib_bad;
    logic                  w_any_bad;

    // One right shift moves the lowest BCD bit into the top of the binary part.
    assign w_shift = r_work >> 1;
    assign w_next[BIN_W-1:0] = w_shift[BIN_W-1:0];

    // After the shift, a digit >= 8 received a borrowed "ten" from the digit
    // above worth 8 instead of 5; subtracting 3 restores a valid BCD digit.
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            logic [3:0] w_nib;
            assign w_nib = w_shift[BIN_W + 4*d +: 4];
            assign w_next[BIN_W + 4*d +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
        end
    endgenerate

    // Flag any operand digit outside 0..9.
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_check
            assign w_nib_bad[d] = (bus.bcd_in[4*d +: 4] > 4'd9);
        end
    endgenerate
    assign w_any_bad = |w_nib_bad;

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_work    <= '0;
            r_cnt     <= '0;
            r_invalid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bin     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (w_any_bad) begin
                            r_invalid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_invalid <= 1'b0;
                            r_work    <= {bus.bcd_in, {BIN_W{1'b0}}};
                            r_cnt     <= '0;
                            r_state   <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_bin   <= r_invalid ? '0 : r_work[BIN_W-1:0];
                    r_err   <= r_invalid;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bin_out = r_bin;
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Purpose  : Directed self-checking bench for bcd_to_bin (DIGITS=6, BIN_W=20)
//            with a decimal reference model for the random sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

    localparam int c_DIGITS = 6;
    localparam int c_BIN_W  = 20;
    localparam int c_LAT    = 21;

    logic sys_clk;
    logic sys_rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    bcd_to_bin_if #(.DIGITS(c_DIGITS), .BIN_W(c_BIN_W)) bus ();

    bcd_to_bin #(.DIGITS(c_DIGITS), .BIN_W(c_BIN_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // 50 MHz clock.
    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal weighting of the packed digits, independent of the shift algorithm.
    function automatic logic [19:0] ref_bin(input logic [23:0] b);
        int v;
        v = 0;
        for (int i = c_DIGITS - 1; i >= 0; i--) begin
            v = v * 10 + int'(b[4*i +: 4]);
        end
        return 20'(v);
    endfunction

    // Caller sits 1 ns after a rising edge with the DUT idle and start low.
    task automatic convert(input logic [23:0] bcd, input logic [19:0] eb,
                           input logic ee, input int el, input string tag);
        int lat;
        bit busy_ok;
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(posedge sys_clk); #1;
        bus.start  = 1'b0;
        bus.bcd_in = 24'hFFFFFF;
        busy_ok = (bus.busy === 1'b1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge sys_clk); #1;
            lat++;
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        check(32'(lat), 32'(el), {tag, " latency"});
        check(32'(bus.bin_out), 32'(eb), {tag, " bin_out"});
        check(32'(bus.err), 32'(ee), {tag, " err"});
        check(32'(busy_ok), 32'd1, {tag, " busy while converting"});
        check(32'(bus.busy), 32'd0, {tag, " busy in done cycle"});
        @(posedge sys_clk); #1;
        check(32'(bus.done), 32'd0, {tag, " done width"});
        check(32'(bus.bin_out), 32'(eb), {tag, " bin_out held"});
    endtask

    initial begin
        int lat;
        int n_done;
        int dlat;
        logic [23:0] v;

        bus.start  = 1'b0;
        bus.bcd_in = '0;
        sys_rst_n  = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check(32'(bus.busy), 32'd0, "reset busy");
        check(32'(bus.done), 32'd0, "reset done");
        check(32'(bus.bin_out), 32'd0, "reset bin_out");
        check(32'(bus.err), 32'd0, "reset err");
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Basic conversions.
        convert(24'h000000, 20'd0,      1'b0, c_LAT, "zero");
        convert(24'h999999, 20'hF423F,  1'b0, c_LAT, "999999");
        convert(24'h123456, 20'h1E240,  1'b0, c_LAT, "123456");

        // Invalid digits, then recovery.
        convert(24'h00000A, 20'd0,      1'b1, 1,     "invalid units");
        convert(24'h000042, 20'd42,     1'b0, c_LAT, "42 after invalid");
        convert(24'hA00000, 20'd0,      1'b1, 1,     "invalid top digit");
        convert(24'h0F0000, 20'd0,      1'b1, 1,     "invalid digit4");

        // Start held high during busy: ignored until IDLE.
        bus.start  = 1'b1;
        bus.bcd_in = 24'h000123;
        @(posedge sys_clk); #1;
        bus.bcd_in = 24'h000999;
        n_done = 0;
        dlat   = 0;
        lat    = 0;
        while (lat < c_LAT) begin
            @(posedge sys_clk); #1;
            lat++;
            if (bus.done === 1'b1) begin
                n_done++;
                dlat = lat;
            end
        end
        check(32'(n_done), 32'd1, "held start single done");
        check(32'(dlat), 32'(c_LAT), "held start latency");
        check(32'(bus.bin_out), 32'd123, "held start bin_out");
        @(posedge sys_clk); #1;
        check(32'(bus.busy), 32'd1, "held start accepted in idle");
        check(32'(bus.done), 32'd0, "held start done cleared");
        check(32'(bus.bin_out), 32'd123, "bin_out stable during next");
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        check(32'(lat), 32'(c_LAT), "second request latency");
        check(32'(bus.bin_out), 32'd999, "second request bin_out");
        @(posedge sys_clk); #1;

        // Reset in the middle of a conversion.
        bus.start  = 1'b1;
        bus.bcd_in = 24'h000777;
        @(posedge sys_clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge sys_clk);
        #5;
        sys_rst_n = 1'b0;
        #2;
        check(32'(bus.busy), 32'd0, "abort busy");
        check(32'(bus.done), 32'd0, "abort done");
        check(32'(bus.bin_out), 32'd0, "abort bin_out");
        check(32'(bus.err), 32'd0, "abort err");
        repeat (2) @(posedge sys_clk);
        #4;
        sys_rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge sys_clk); #1;
            if (bus.done === 1'b1) n_done++;
        end
        check(32'(n_done), 32'd0, "no done after abort");
        convert(24'h000500, 20'd500, 1'b0, c_LAT, "500 after abort");

        // Edge values and random valid sweep against the decimal model.
        convert(24'h000001, 20'd1,      1'b0, c_LAT, "000001");
        convert(24'h100000, 20'd100000, 1'b0, c_LAT, "100000");
        convert(24'h099999, 20'd99999,  1'b0, c_LAT, "099999");
        for (int n = 0; n < 1000; n++) begin
            for (int d = 0; d < c_DIGITS; d++) begin
                v[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            convert(v, ref_bin(v), 1'b0, c_LAT, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
